lt24_bus_decoder: RTL and testbench
===================================

Name: lt24_bus_decoder

Overview:
- Synthesisable display-side decoder for the LT24 8080-style write bus: the responder to the bus driven by our drawing blocks.
- Decodes command and parameter writes and tracks the column/page address window, as the LCD controller does.
- Emits one pixel write per memory-write data cycle, tagged with its (x,y) coordinate.
- Used on-chip for framebuffer capture and self-checking, and as a synthesisable replacement for the display functional model.

Parameters:
- WIDTH, 240, display columns; reset end column = WIDTH-1
- HEIGHT, 320, display rows; reset end page = HEIGHT-1
- X_BITS, 8, width of pixelX
- Y_BITS, 9, width of pixelY

Ports:
- clock  in  1  system clock, same domain as the bus driver
- reset  in  1  synchronous, active-high
- LT24Wr_n  in  1  write strobe, active low
- LT24CS_n  in  1  chip select, active low
- LT24RS  in  1  0 = command, 1 = data/parameter
- LT24Reset_n  in  1  display reset, active low
- LT24Data  in  16  bus data; commands/parameters use [7:0]
- pixelValid  out  1  one-cycle pulse per decoded pixel
- pixelX  out  X_BITS  pixel column
- pixelY  out  Y_BITS  pixel row
- pixelData  out  16  RGB565 pixel value
- cmdValid  out  1  one-cycle pulse per command write
- cmdCode  out  8  last command byte
- frameDone  out  1  pulse when the cursor wraps past (EC,EP)
- rangeError  out  1  pulse on a rejected window or out-of-display pixel

Behaviour:
- Reset:
  - Synchronous; reset=1, or LT24Reset_n=0 sampled at a clock edge, has identical effect and wins over any simultaneous write.
  - All outputs are 0 and the FSM enters IDLE.
  - Window registers: SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1. Cursor: (0,0).
  - Reset mid-stream discards any partial parameter sequence.
- Write capture:
  - Each cycle in which Wr_n=0 registers {RS, Data}.
  - A write event occurs in the first cycle where Wr_n=1 and the previous cycle had Wr_n=0, provided CS_n=0 in that cycle. Otherwise the edge is ignored.
  - The event uses the captured {RS, Data}.
  - All outputs are registered and change one clock after the event cycle.
  - Back-to-back writes (Wr_n low for 1 cycle, high for 1 cycle) must be decoded without loss.
- Command writes (RS=0):
  - Pulse cmdValid and update cmdCode = Data[7:0].
  - A command always aborts the current state; no partial window update occurs.
  - 0x2A goes to COL_P, paramIdx=0. 0x2B goes to PAGE_P, paramIdx=0.
  - 0x2C: cursor=(SC,SP), go to MEM_WR. 0x3C: go to MEM_WR, cursor unchanged.
  - 0x01 (software reset): window and cursor take their reset values; go to IDLE.
  - Any other code goes to IGNORE.
- Data writes (RS=1):
  - IDLE / IGNORE: discarded.
  - COL_P / PAGE_P:
    - Byte n (n=0..3) is stored; start = {b0,b1}, end = {b2,b3}.
    - After byte 3, commit only if start<=end and end<WIDTH (col) or end<HEIGHT (page). Otherwise pulse rangeError and keep the old window.
    - Go to IDLE after byte 3 either way.
  - MEM_WR:
    - Pulse pixelValid with pixelX/pixelY = cursor and pixelData = Data.
    - Advance: x=x+1; if x==EC, x=SC and y=y+1. If additionally y==EP, set y=SP and pulse frameDone in the same cycle as the last pixel.
    - Stay in MEM_WR.
- FSM states: IDLE, COL_P, PAGE_P, MEM_WR, IGNORE. The 2-bit paramIdx counter is cleared on every command.
- Cursor arithmetic is 16-bit internally. pixelX/pixelY are truncated to X_BITS/Y_BITS; the window checks guarantee in-range coordinates.

Decomposition:
- Package lt24_cmd_pkg: command constants (CMD_SWRESET 0x01, CMD_CASET 0x2A, CMD_PASET 0x2B, CMD_RAMWR 0x2C, CMD_RAMWRC 0x3C) and the FSM state encoding.
- Sub-module lt24_write_strobe: Wr_n edge detect, CS qualification and {RS, Data} capture. Outputs wrEvent, wrRS, wrData.
- The top level holds the FSM, window registers and cursor.

Test Plan:
- Reset, then 0x2C followed by 3 data words 0xF800, 0x07E0, 0x001F: pixels at (0,0), (1,0), (2,0) with matching data, each exactly 1 clock after its Wr_n rising edge.
- CASET params 00,0A,00,0B; PASET params 00,0A,00,0B; RAMWR; 4 data words: pixels at (10,10), (11,10), (10,11), (11,11), with frameDone on the 4th; a 5th word goes to (10,10).
- CASET params 00,0F,00,05 (start>end): rangeError pulse; a following RAMWR starts at the old window origin.
- Writes with CS_n=1, and a CASET aborted by RAMWR after 2 params: no pixels and no window change for the CS_n=1 writes; the aborted CASET leaves the window unchanged.
- LT24Reset_n low for 1 cycle mid-MEM_WR, then data words: no pixelValid until a new 0x2C; after it, the cursor restarts at (0,0).
- Back-to-back 1-low/1-high writes of 240 RAMWR pixels: 240 pulses, then the cursor moves to (0,1).

Source files
------------

// File: rtl/lt24_cmd_pkg.sv
// Command codes, FSM state encoding and the window-range helper
// shared by the LT24 bus decoder.
package lt24_cmd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COL_P  = 3'd1,
    ST_PAGE_P = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  // A window is accepted only when it is ordered and ends inside the display.
  function automatic logic win_ok(input logic [15:0] start_v,
                                  input logic [15:0] end_v,
                                  input logic [15:0] limit_v);
    return (start_v <= end_v) && (end_v < limit_v);
  endfunction

endpackage

// File: rtl/lt24_bus_decoder_if.sv
// LT24 8080-style write bus: the drawing blocks drive it, the decoder listens.
interface lt24_bus_decoder_if;
  logic        LT24Wr_n;
  logic        LT24CS_n;
  logic        LT24RS;
  logic        LT24Reset_n;
  logic [15:0] LT24Data;

  modport master (output LT24Wr_n, LT24CS_n, LT24RS, LT24Reset_n, LT24Data);
  modport slave  (input  LT24Wr_n, LT24CS_n, LT24RS, LT24Reset_n, LT24Data);
endinterface

// File: rtl/lt24_write_strobe.sv
// Turns the Wr_n rising edge into a single-cycle write event carrying the
// {RS, Data} that was on the bus while the strobe was low.
module lt24_write_strobe (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_n,
  input  logic        cs_n,
  input  logic        rs,
  input  logic [15:0] data,
  output logic        wrEvent,
  output logic        wrRS,
  output logic [15:0] wrData
);

  logic        wr_n_q;
  logic        cap_rs_q;
  logic [15:0] cap_data_q;

  // Track the previous strobe level and latch the bus on every low cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_n_q     <= 1'b1;
      cap_rs_q   <= 1'b0;
      cap_data_q <= 16'h0000;
    end else begin
      wr_n_q <= wr_n;
      if (!wr_n) begin
        cap_rs_q   <= rs;
        cap_data_q <= data;
      end
    end
  end

  // Chip select is judged in the cycle the strobe returns high.
  assign wrEvent = wr_n & ~wr_n_q & ~cs_n;
  assign wrRS    = cap_rs_q;
  assign wrData  = cap_data_q;

endmodule

// File: rtl/lt24_bus_decoder.sv
// Display-side decoder for the LT24 write bus: tracks the address window
// and cursor like the LCD controller and emits tagged pixel writes.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | no command in progress, data writes dropped
// ST_COL_P  | collecting 4 column-address parameter bytes
// ST_PAGE_P | collecting 4 page-address parameter bytes
// ST_MEM_WR | each data write is a pixel at the cursor
// ST_IGNORE | unsupported command, data writes dropped
module lt24_bus_decoder
  import lt24_cmd_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320,
  parameter int X_BITS = 8,
  parameter int Y_BITS = 9
) (
  input  logic                clock,
  input  logic                reset,
  lt24_bus_decoder_if.slave   lt24,
  output logic                pixelValid,
  output logic [X_BITS-1:0]   pixelX,
  output logic [Y_BITS-1:0]   pixelY,
  output logic [15:0]         pixelData,
  output logic                cmdValid,
  output logic [7:0]          cmdCode,
  output logic                frameDone,
  output logic                rangeError
);

  localparam logic [15:0] W_LIM = 16'(WIDTH);
  localparam logic [15:0] H_LIM = 16'(HEIGHT);
  localparam logic [15:0] W_END = 16'(WIDTH - 1);
  localparam logic [15:0] H_END = 16'(HEIGHT - 1);

  logic        rst_all;
  logic        wrEvent;
  logic        wrRS;
  logic [15:0] wrData;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [15:0] cx_q, cx_d, cy_q, cy_d;
  logic [15:0] p_start, p_end;

  logic              pv_d, cv_d, fd_d, re_d;
  logic [X_BITS-1:0] px_d;
  logic [Y_BITS-1:0] py_d;
  logic [15:0]       pd_d;
  logic [7:0]        cc_d;

  // Display reset on the bus behaves exactly like the block reset.
  assign rst_all = reset | ~lt24.LT24Reset_n;

  lt24_write_strobe u_strobe (
    .clock   (clock),
    .reset   (rst_all),
    .wr_n    (lt24.LT24Wr_n),
    .cs_n    (lt24.LT24CS_n),
    .rs      (lt24.LT24RS),
    .data    (lt24.LT24Data),
    .wrEvent (wrEvent),
    .wrRS    (wrRS),
    .wrData  (wrData)
  );

  // The fourth parameter byte is used straight off the bus capture.
  assign p_start = {b0_q, b1_q};
  assign p_end   = {b2_q, wrData[7:0]};

  // Decode each write event into state, window, cursor and output updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    sc_d    = sc_q;
    ec_d    = ec_q;
    sp_d    = sp_q;
    ep_d    = ep_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    pv_d    = 1'b0;
    px_d    = pixelX;
    py_d    = pixelY;
    pd_d    = pixelData;
    cv_d    = 1'b0;
    cc_d    = cmdCode;
    fd_d    = 1'b0;
    re_d    = 1'b0;
    if (wrEvent) begin
      if (!wrRS) begin
        cv_d  = 1'b1;
        cc_d  = wrData[7:0];
        idx_d = 2'd0;
        case (wrData[7:0])
          CMD_CASET:  state_d = ST_COL_P;
          CMD_PASET:  state_d = ST_PAGE_P;
          CMD_RAMWR: begin
            cx_d    = sc_q;
            cy_d    = sp_q;
            state_d = ST_MEM_WR;
          end
          CMD_RAMWRC: state_d = ST_MEM_WR;
          CMD_SWRESET: begin
            sc_d    = 16'h0000;
            ec_d    = W_END;
            sp_d    = 16'h0000;
            ep_d    = H_END;
            cx_d    = 16'h0000;
            cy_d    = 16'h0000;
            state_d = ST_IDLE;
          end
          default:    state_d = ST_IGNORE;
        endcase
      end else begin
        case (state_q)
          ST_COL_P, ST_PAGE_P: begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0:    b0_d = wrData[7:0];
              2'd1:    b1_d = wrData[7:0];
              2'd2:    b2_d = wrData[7:0];
              default: begin
                state_d = ST_IDLE;
                if (state_q == ST_COL_P) begin
                  if (win_ok(p_start, p_end, W_LIM)) begin
                    sc_d = p_start;
                    ec_d = p_end;
                  end else begin
                    re_d = 1'b1;
                  end
                end else begin
                  if (win_ok(p_start, p_end, H_LIM)) begin
                    sp_d = p_start;
                    ep_d = p_end;
                  end else begin
                    re_d = 1'b1;
                  end
                end
              end
            endcase
          end
          ST_MEM_WR: begin
            // A cursor left outside the display (RAMWRC after a shrink)
            // is flagged instead of emitting a truncated coordinate.
            if ((cx_q < W_LIM) && (cy_q < H_LIM)) begin
              pv_d = 1'b1;
              px_d = cx_q[X_BITS-1:0];
              py_d = cy_q[Y_BITS-1:0];
              pd_d = wrData;
            end else begin
              re_d = 1'b1;
            end
            if (cx_q == ec_q) begin
              cx_d = sc_q;
              if (cy_q == ep_q) begin
                cy_d = sp_q;
                fd_d = 1'b1;
              end else begin
                cy_d = cy_q + 16'd1;
              end
            end else begin
              cx_d = cx_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State, window, cursor and registered outputs.
  always_ff @(posedge clock) begin
    if (rst_all) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      b0_q       <= 8'h00;
      b1_q       <= 8'h00;
      b2_q       <= 8'h00;
      sc_q       <= 16'h0000;
      ec_q       <= W_END;
      sp_q       <= 16'h0000;
      ep_q       <= H_END;
      cx_q       <= 16'h0000;
      cy_q       <= 16'h0000;
      pixelValid <= 1'b0;
      pixelX     <= '0;
      pixelY     <= '0;
      pixelData  <= 16'h0000;
      cmdValid   <= 1'b0;
      cmdCode    <= 8'h00;
      frameDone  <= 1'b0;
      rangeError <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      sc_q       <= sc_d;
      ec_q       <= ec_d;
      sp_q       <= sp_d;
      ep_q       <= ep_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      pixelValid <= pv_d;
      pixelX     <= px_d;
      pixelY     <= py_d;
      pixelData  <= pd_d;
      cmdValid   <= cv_d;
      cmdCode    <= cc_d;
      frameDone  <= fd_d;
      rangeError <= re_d;
    end
  end

endmodule

// File: tb/tb_lt24_bus_decoder.sv
// Self-checking bench for lt24_bus_decoder: directed scenarios with literal
// expectations, then randomized bus traffic against a behavioural model.
module tb_lt24_bus_decoder;

  localparam int WIDTH  = 240;
  localparam int HEIGHT = 320;
  localparam int M_IDLE = 0;
  localparam int M_COL  = 1;
  localparam int M_PAGE = 2;
  localparam int M_MEM  = 3;
  localparam int M_IGN  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pixelValid;
  logic [7:0]  pixelX;
  logic [8:0]  pixelY;
  logic [15:0] pixelData;
  logic        cmdValid;
  logic [7:0]  cmdCode;
  logic        frameDone;
  logic        rangeError;

  lt24_bus_decoder_if bus ();

  lt24_bus_decoder #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_BITS(8), .Y_BITS(9)) dut (
    .clock      (clock),
    .reset      (reset),
    .lt24       (bus),
    .pixelValid (pixelValid),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .pixelData  (pixelData),
    .cmdValid   (cmdValid),
    .cmdCode    (cmdCode),
    .frameDone  (frameDone),
    .rangeError (rangeError)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // behavioural model of the display controller
  int          m_mode = M_IDLE;
  int          m_np = 0;
  int          m_prm [4];
  int          m_sc = 0, m_ec = WIDTH - 1, m_sp = 0, m_ep = HEIGHT - 1;
  logic [15:0] m_cx = 16'h0, m_cy = 16'h0;
  logic [7:0]  m_px = 8'h0;
  logic [8:0]  m_py = 9'h0;
  logic [15:0] m_pd = 16'h0;
  logic [7:0]  m_cc = 8'h0;
  bit          p_pv = 0, p_cv = 0, p_fd = 0, p_re = 0;

  // expectations that apply in the current cycle
  bit          e_pv = 0, e_cv = 0, e_fd = 0, e_re = 0;
  logic [7:0]  e_px = 8'h0;
  logic [8:0]  e_py = 9'h0;
  logic [15:0] e_pd = 16'h0;
  logic [7:0]  e_cc = 8'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = M_IDLE; m_np = 0;
    m_sc = 0; m_ec = WIDTH - 1; m_sp = 0; m_ep = HEIGHT - 1;
    m_cx = 16'h0; m_cy = 16'h0;
    m_px = 8'h0; m_py = 9'h0; m_pd = 16'h0; m_cc = 8'h0;
    p_pv = 0; p_cv = 0; p_fd = 0; p_re = 0;
  endtask

  task automatic m_event(input bit rs, input logic [15:0] d);
    int s, e, lim;
    if (!rs) begin
      p_cv = 1; m_cc = d[7:0]; m_np = 0;
      case (d[7:0])
        8'h2A: m_mode = M_COL;
        8'h2B: m_mode = M_PAGE;
        8'h2C: begin m_cx = 16'(m_sc); m_cy = 16'(m_sp); m_mode = M_MEM; end
        8'h3C: m_mode = M_MEM;
        8'h01: begin
          m_sc = 0; m_ec = WIDTH - 1; m_sp = 0; m_ep = HEIGHT - 1;
          m_cx = 16'h0; m_cy = 16'h0; m_mode = M_IDLE;
        end
        default: m_mode = M_IGN;
      endcase
    end else if (m_mode == M_COL || m_mode == M_PAGE) begin
      m_prm[m_np] = int'(d[7:0]);
      m_np++;
      if (m_np == 4) begin
        s = m_prm[0] * 256 + m_prm[1];
        e = m_prm[2] * 256 + m_prm[3];
        lim = (m_mode == M_COL) ? WIDTH : HEIGHT;
        if (s <= e && e < lim) begin
          if (m_mode == M_COL) begin m_sc = s; m_ec = e; end
          else begin m_sp = s; m_ep = e; end
        end else p_re = 1;
        m_mode = M_IDLE; m_np = 0;
      end
    end else if (m_mode == M_MEM) begin
      if (int'(m_cx) < WIDTH && int'(m_cy) < HEIGHT) begin
        p_pv = 1; m_px = m_cx[7:0]; m_py = m_cy[8:0]; m_pd = d;
      end else p_re = 1;
      if (int'(m_cx) == m_ec) begin
        m_cx = 16'(m_sc);
        if (int'(m_cy) == m_ep) begin m_cy = 16'(m_sp); p_fd = 1; end
        else m_cy = m_cy + 16'd1;
      end else m_cx = m_cx + 16'd1;
    end
  endtask

  // model results become visible one clock after the event cycle
  always @(posedge clock) begin
    e_pv = p_pv; e_cv = p_cv; e_fd = p_fd; e_re = p_re;
    p_pv = 0; p_cv = 0; p_fd = 0; p_re = 0;
    e_px = m_px; e_py = m_py; e_pd = m_pd; e_cc = m_cc;
  end

  // every-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("pixelValid", 32'(pixelValid), 32'(e_pv));
      chk("pixelX", 32'(pixelX), 32'(e_px));
      chk("pixelY", 32'(pixelY), 32'(e_py));
      chk("pixelData", 32'(pixelData), 32'(e_pd));
      chk("cmdValid", 32'(cmdValid), 32'(e_cv));
      chk("cmdCode", 32'(cmdCode), 32'(e_cc));
      chk("frameDone", 32'(frameDone), 32'(e_fd));
      chk("rangeError", 32'(rangeError), 32'(e_re));
    end
  end

  // called at posedge+1; returns at posedge+1 with the event's outputs visible when high==1
  task automatic wr(input bit rs, input logic [15:0] d, input bit cs_n = 1'b0,
                    input int low = 1, input int high = 1);
    bus.LT24CS_n = cs_n; bus.LT24RS = rs; bus.LT24Data = d; bus.LT24Wr_n = 1'b0;
    repeat (low) @(posedge clock);
    #1;
    bus.LT24Wr_n = 1'b1;
    if (!cs_n) m_event(rs, d);
    repeat (high) begin @(posedge clock); #1; end
  endtask

  task automatic lcd_reset(input bit use_pin, input bit with_event);
    if (with_event) begin
      bus.LT24CS_n = 1'b0; bus.LT24RS = 1'b1; bus.LT24Data = 16'hBEEF; bus.LT24Wr_n = 1'b0;
      @(posedge clock); #1;
      bus.LT24Wr_n = 1'b1;
    end
    if (use_pin) reset = 1'b1; else bus.LT24Reset_n = 1'b0;
    m_reset();
    @(posedge clock); #1;
    reset = 1'b0; bus.LT24Reset_n = 1'b1;
  endtask

  task automatic pix(input string name, input int x, input int y, input logic [15:0] d);
    chk({name, "_valid"}, 32'(pixelValid), 32'd1);
    chk({name, "_x"}, 32'(pixelX), 32'(x));
    chk({name, "_y"}, 32'(pixelY), 32'(y));
    chk({name, "_data"}, 32'(pixelData), 32'(d));
  endtask

  task automatic window(input bit col, input int s, input int e, input int nparams);
    logic [7:0] b [4];
    b[0] = 8'(s >> 8); b[1] = 8'(s); b[2] = 8'(e >> 8); b[3] = 8'(e);
    wr(1'b0, col ? 16'h002A : 16'h002B, 1'b0, $urandom_range(1, 2), $urandom_range(1, 2));
    for (int i = 0; i < nparams; i++)
      wr(1'b1, {8'($urandom), b[i]}, 1'b0, $urandom_range(1, 2), $urandom_range(1, 2));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not end within its time limit");
    $fatal(1, "watchdog");
  end

  int n_pix;

  initial begin
    bus.LT24Wr_n = 1'b1; bus.LT24CS_n = 1'b1; bus.LT24RS = 1'b0;
    bus.LT24Reset_n = 1'b1; bus.LT24Data = 16'h0;
    m_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_pixelValid", 32'(pixelValid), 32'd0);
    chk("rst_cmdCode", 32'(cmdCode), 32'd0);
    chk("rst_pixelData", 32'(pixelData), 32'd0);

    // first pixels after RAMWR
    wr(1'b0, 16'h002C);
    chk("t1_cmdValid", 32'(cmdValid), 32'd1);
    chk("t1_cmdCode", 32'(cmdCode), 32'h2C);
    wr(1'b1, 16'hF800); pix("t1_p0", 0, 0, 16'hF800);
    wr(1'b1, 16'h07E0); pix("t1_p1", 1, 0, 16'h07E0);
    wr(1'b1, 16'h001F); pix("t1_p2", 2, 0, 16'h001F);

    // 2x2 window with wrap and frameDone
    window(1'b1, 10, 11, 4);
    window(1'b0, 10, 11, 4);
    wr(1'b0, 16'h002C);
    wr(1'b1, 16'h1111); pix("t2_p0", 10, 10, 16'h1111);
    chk("t2_fd0", 32'(frameDone), 32'd0);
    wr(1'b1, 16'h2222); pix("t2_p1", 11, 10, 16'h2222);
    wr(1'b1, 16'h3333); pix("t2_p2", 10, 11, 16'h3333);
    wr(1'b1, 16'h4444); pix("t2_p3", 11, 11, 16'h4444);
    chk("t2_fd3", 32'(frameDone), 32'd1);
    wr(1'b1, 16'h5555); pix("t2_p4", 10, 10, 16'h5555);

    // rejected window keeps the old one
    window(1'b1, 15, 5, 4);
    chk("t3_rangeError", 32'(rangeError), 32'd1);
    wr(1'b0, 16'h002C);
    wr(1'b1, 16'h6666); pix("t3_p0", 10, 10, 16'h6666);

    // CS_n high writes ignored, aborted CASET changes nothing
    wr(1'b0, 16'h002A, 1'b1);
    chk("t4_cs_cmd", 32'(cmdValid), 32'd0);
    wr(1'b1, 16'h1234, 1'b1);
    chk("t4_cs_pix", 32'(pixelValid), 32'd0);
    wr(1'b1, 16'hABCD); pix("t4_p0", 11, 10, 16'hABCD);
    window(1'b1, 0, 0, 2);
    wr(1'b0, 16'h002C);
    wr(1'b1, 16'h7777); pix("t4_p1", 10, 10, 16'h7777);

    // display reset mid-stream
    lcd_reset(1'b0, 1'b0);
    chk("t5_cmdCode", 32'(cmdCode), 32'd0);
    wr(1'b1, 16'h8888);
    chk("t5_nopix", 32'(pixelValid), 32'd0);
    wr(1'b0, 16'h002C);
    wr(1'b1, 16'h9999); pix("t5_p0", 0, 0, 16'h9999);

    // full line of back-to-back writes
    wr(1'b0, 16'h002C);
    n_pix = 0;
    for (int i = 0; i < WIDTH; i++) begin
      wr(1'b1, 16'(i));
      if (pixelValid === 1'b1) n_pix++;
    end
    chk("t6_count", 32'(n_pix), 32'd240);
    wr(1'b1, 16'hAAAA); pix("t6_next", 0, 1, 16'hAAAA);

    // randomized traffic
    for (int op = 0; op < 250; op++) begin
      int k, lim, s, e;
      k = $urandom_range(0, 12);
      case (k)
        0, 1: begin
          lim = (k == 0) ? WIDTH : HEIGHT;
          s = $urandom_range(0, lim + 8);
          e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lim + 8) : s + $urandom_range(0, 4);
          window(k == 0, s, e, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : 4);
        end
        2, 3, 4, 5: begin
          wr(1'b0, (k == 5) ? 16'h003C : 16'h002C, 1'b0, $urandom_range(1, 2), $urandom_range(1, 2));
          repeat ($urandom_range(1, 12))
            wr(1'b1, 16'($urandom), 1'b0, $urandom_range(1, 2), $urandom_range(1, 2));
        end
        6: wr(1'b0, 16'h0001);
        7: begin
          wr(1'b0, 16'($urandom_range(0, 1) ? 8'h55 : 8'h00));
          wr(1'b1, 16'($urandom));
        end
        8: wr(1'b1, 16'($urandom), 1'b0, $urandom_range(1, 3), $urandom_range(1, 2));
        9: wr(1'($urandom), 16'($urandom), 1'b1, $urandom_range(1, 2), 1);
        10: if ($urandom_range(0, 3) == 0) lcd_reset(1'($urandom), 1'($urandom));
        default: repeat ($urandom_range(1, 4)) begin @(posedge clock); #1; end
      endcase
    end

    repeat (3) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
